// File: rtl/seq_nonrestoring_divider_if.sv
// Operand/result handshake bundle for seq_nonrestoring_divider.
// The requester drives the master side, the divider the slave side.
interface seq_nonrestoring_divider_if #(
    parameter int WIDTH     = 24,
    parameter int FRAC_BITS = 26
);
    localparam int QW = WIDTH + FRAC_BITS;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [QW-1:0]    quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder,
        input  div_by_zero, busy
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder,
        output div_by_zero, busy
    );
endinterface

// File: rtl/seq_nonrestoring_divider.sv
// Iterative unsigned non-restoring divider, one quotient bit per clock.
// Dividend is pre-shifted by FRAC_BITS; a FIX cycle corrects the remainder.
module seq_nonrestoring_divider #(
    parameter int WIDTH     = 24,
    parameter int FRAC_BITS = 26,
    parameter int CNT_W     = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    seq_nonrestoring_divider_if.slave     bus
);
    localparam int QW = WIDTH + FRAC_BITS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [WIDTH:0]   r_a;
    logic [QW-1:0]    r_q;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic [QW-1:0]    r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH:0]   w_new_a;
    logic [WIDTH:0]   w_fix_a;

    // |A| < B keeps the shifted partial remainder inside WIDTH+1 bits,
    // so the top bit of the WIDTH+2 bit shift can be dropped up front.
    assign w_shift = {r_a[WIDTH-1:0], r_q[QW-1]};
    assign w_b_ext = {1'b0, r_b};
    assign w_new_a = r_a[WIDTH] ? (w_shift + w_b_ext)
                                : (w_shift - w_b_ext);
    assign w_fix_a = r_a[WIDTH] ? (r_a + w_b_ext) : r_a;

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = (r_state == S_DONE);
    assign bus.busy        = (r_state == S_RUN) || (r_state == S_FIX);
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.divisor == '0) begin
                            r_quot  <= '1;
                            r_rem   <= '0;
                            r_dbz   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_a     <= '0;
                            r_q     <= QW'(bus.dividend) << FRAC_BITS;
                            r_b     <= bus.divisor;
                            r_cnt   <= '0;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_a   <= w_new_a;
                    r_q   <= {r_q[QW-2:0], ~w_new_a[WIDTH]};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(QW - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_a     <= w_fix_a;
                    r_quot  <= r_q;
                    r_rem   <= w_fix_a[WIDTH-1:0];
                    r_dbz   <= 1'b0;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/seq_nonrestoring_divider.md
Name: seq_nonrestoring_divider

Overview:
- Iterative, parametrised unsigned non-restoring divider. Produces one quotient bit per clock.
- Successor to the combinational 50-stage array divider. Reuses the same arithmetic: dividend pre-shifted by FRAC_BITS, quotient of WIDTH+FRAC_BITS bits.
- Adds a final remainder-correction step, a divide-by-zero flag, and valid/ready handshakes on both sides.
- Sits in the FP divide datapath and divides mantissas (24-bit default).

Parameters:
- WIDTH, 24: operand width (dividend, divisor, remainder).
- FRAC_BITS, 26: zero bits appended below the dividend. Quotient width QW = WIDTH+FRAC_BITS.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > QW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dividend  in  WIDTH  unsigned dividend.
- divisor  in  WIDTH  unsigned divisor.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- quotient  out  QW  floor((dividend<<FRAC_BITS)/divisor).
- remainder  out  WIDTH  (dividend<<FRAC_BITS) mod divisor.
- div_by_zero  out  1  divisor was zero.
- busy  out  1  high in RUN or FIX.

Behaviour:
- Reset (async, any state) forces:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - quotient=0, remainder=0, div_by_zero=0, counter=0, A=0.
- Internal registers:
  - A: WIDTH+1 bits, two's complement, partial remainder.
  - Q: QW bits.
  - B: WIDTH bits.
  - cnt: CNT_W bits.
- IDLE:
  - in_ready=1.
  - On in_valid, with divisor!=0: load A=0, Q={dividend, FRAC_BITS zeros}, B=divisor, cnt=0. Go to RUN.
  - On in_valid, with divisor==0: quotient=all ones, remainder=0, div_by_zero=1. Go to DONE.
- RUN:
  - Each cycle, form S = {A, Q[QW-1]} as WIDTH+2 bits signed (A sign-extended, shifted left, Q MSB appended).
  - If A sign=0: S-B. Else: S+B.
  - Store the result truncated to WIDTH+1 bits into A. This is lossless because |A| < B is invariant.
  - Q <= {Q[QW-2:0], ~newA[WIDTH]}.
  - cnt increments. When cnt==QW-1 on the current cycle, go to FIX.
- FIX (one cycle):
  - If A negative: A <= A+B.
  - Quotient output <= Q. Remainder output <= corrected A[WIDTH-1:0]. div_by_zero <= 0.
  - Go to DONE.
- DONE:
  - out_valid=1. quotient, remainder and div_by_zero are stable.
  - On out_ready: go to IDLE, out_valid drops next cycle.
  - in_ready is 0 in DONE. A new operation cannot be accepted in the same cycle the result is taken; in_ready rises the cycle after.
- Latency:
  - Acceptance edge to out_valid high: QW+2 edges (QW RUN + 1 FIX + 1 register). That is 52 edges at the defaults.
  - Divide-by-zero: out_valid high 1 edge after acceptance.
- in_valid outside IDLE is ignored. Operands are sampled only at the acceptance edge; later changes on dividend/divisor have no effect.
- out_ready outside DONE is ignored.
- Result registers hold their last value in IDLE/RUN/FIX and are only meaningful while out_valid=1.
- Reset mid-RUN discards the operation. No out_valid is produced for it.
- Edge cases:
  - dividend=0 gives quotient 0, remainder 0, full latency.
  - divisor=1 gives quotient=dividend<<FRAC_BITS, remainder 0.

Test Plan:
- Defaults, dividend=7, divisor=3 -> after 52 edges: out_valid=1, quotient=0x9555555, remainder=1, div_by_zero=0.
- dividend=1, divisor=2 -> quotient=0x2000000, remainder=0. dividend=0xFFFFFF, divisor=1 -> quotient=0x3FFFFFC000000, remainder=0.
- divisor=0, dividend=0xC80000 -> out_valid one edge after accept; quotient all ones (50 bits), remainder=0, div_by_zero=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid; outputs must stay stable and in_ready=0.
  - Raise out_ready; in_ready=1 on the following cycle, and back-to-back ops are accepted.
- Assert rst at iteration 20 of a 7/3 divide -> all outputs zero, state IDLE. The next 10/4 divide gives quotient=0xA000000, remainder=0.
- Random sweep: 10k random operand pairs (divisor!=0) at WIDTH=8, FRAC_BITS=4 and at the defaults, checked against a reference model of (a<<FRAC_BITS)/b and %b.
